// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch unit feeding the decode stage.
//
// Issues sequential word fetches to instruction memory over a request /
// acknowledge handshake, buffers returned words with their addresses in a
// small prefetch FIFO, and presents one {pc, inst} pair per cycle to decode.
// Decode stall freezes the outputs while fetching continues until the FIFO
// is full. A flush discards everything buffered or in flight and restarts
// fetching at the redirect target.
//
// Ports:
//   i_clk         clock, all state on rising edge
//   i_rst         synchronous active-high reset
//   i_stall       decode cannot accept; hold o_pc/o_inst/o_inst_valid
//   i_flush       redirect: drop buffered and in-flight fetches
//   i_new_pc      redirect target (bits [1:0] forced to zero)
//   o_rom_ce      fetch request valid
//   o_rom_addr    fetch address
//   i_rom_ack     i_rom_data is valid for this cycle's o_rom_addr
//   i_rom_data    instruction word from memory
//   o_pc          address of o_inst
//   o_inst        instruction to decode (0 = nop when no valid word)
//   o_inst_valid  o_inst holds a fetched instruction

module if_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_new_pc,
  output logic        o_rom_ce,
  output logic [31:0] o_rom_addr,
  input  logic        i_rom_ack,
  input  logic [31:0] i_rom_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_inst_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_fpc;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == (AW+1)'(DEPTH));

  // A full FIFO never requests, even when a pop frees a slot this cycle;
  // keeps the request path free of any dependence on i_stall.
  assign o_rom_ce   = ~i_rst & ~i_flush & ~w_full;
  assign o_rom_addr = r_fpc;

  assign w_push = o_rom_ce & i_rom_ack;
  assign w_pop  = ~i_stall & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fpc        <= RESET_PC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      o_pc         <= 32'h0;
      o_inst       <= 32'h0;
      o_inst_valid <= 1'b0;
    end else if (i_flush) begin
      // o_pc deliberately holds; only the valid/inst pair is cleared.
      r_fpc        <= i_new_pc & 32'hFFFF_FFFC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      o_inst       <= 32'h0;
      o_inst_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_tail]   <= r_fpc;
        r_fifo_inst[r_tail] <= i_rom_data;
        r_tail              <= r_tail + 1'b1;
        r_fpc               <= r_fpc + 32'd4;
      end

      if (!i_stall) begin
        if (w_pop) begin
          o_pc         <= r_fifo_pc[r_head];
          o_inst       <= r_fifo_inst[r_head];
          o_inst_valid <= 1'b1;
          r_head       <= r_head + 1'b1;
        end else begin
          o_inst       <= 32'h0;
          o_inst_valid <= 1'b0;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit: the producer end of the `pc`/`inst` interface consumed by the decode stage. Generates sequential fetch addresses, runs a request/acknowledge handshake with instruction memory, buffers returned words in a small prefetch FIFO, and presents one `{pc, inst}` pair per cycle to decode. Honours pipeline stall and redirect/flush from the control logic.

## Interface
- `DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: first fetch address after reset (word aligned).

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `stall_i`  in  1  decode cannot accept; hold `pc_o`/`inst_o`/`inst_valid_o`.
- `flush_i`  in  1  redirect: discard all buffered/in-flight fetches.
- `new_pc_i`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `rom_ce_o`  out  1  fetch request valid.
- `rom_addr_o`  out  32  fetch address.
- `rom_ack_i`  in  1  `rom_data_i` valid for the `rom_addr_o` of this same cycle.
- `rom_data_i`  in  32  instruction word.
- `pc_o`  out  32  address of `inst_o` (to decode `pc_i`).
- `inst_o`  out  32  instruction to decode (`inst_i`).
- `inst_valid_o`  out  1  `inst_o` holds a fetched instruction.

## Operation
- State: fetch PC `fpc`, FIFO of DEPTH `{addr, data}` entries, occupancy `count` (0..DEPTH), registered outputs `pc_o`/`inst_o`/`inst_valid_o`.
- Request: `rom_ce_o = ~rst & ~flush_i & (count < DEPTH)`; `rom_addr_o = fpc`. Address held stable until ack (except on flush). Memory may insert any number of wait cycles.
- Push: cycle with `rom_ce_o & rom_ack_i` → `{fpc, rom_data_i}` written at tail; `fpc <= fpc + 4` (mod 2^32, 32'hFFFF_FFFC wraps to 0).
- Pop: when `~stall_i` and `count > 0` → head loaded into `pc_o`/`inst_o`, `inst_valid_o <= 1`. When `~stall_i` and FIFO empty → `inst_o <= 0` (decodes as nop), `inst_valid_o <= 0`, `pc_o` holds.
- `stall_i = 1`: outputs and FIFO head untouched; fetching continues until FIFO full.
- Push and pop in same cycle: `count` unchanged, both take effect.
- Full (`count == DEPTH`): no request issued that cycle, even if a pop occurs (no same-cycle refill).
- Flush (priority over stall, push, pop): `count <= 0`, `fpc <= {new_pc_i[31:2], 2'b00}`, `inst_o <= 0`, `inst_valid_o <= 0`, `pc_o` holds. `rom_ce_o` is 0 in the flush cycle, so any ack that cycle is ignored; abandoned request is not resumed.
- Reset (priority over all, including mid-wait): `fpc <= RESET_PC`, `count <= 0`, `pc_o <= 0`, `inst_o <= 0`, `inst_valid_o <= 0`; `rom_ce_o = 0` while `rst = 1`.

## Timing
- Reset values: `pc_o` 0, `inst_o` 0, `inst_valid_o` 0, `rom_ce_o` 0, `rom_addr_o` = RESET_PC (don't-care while ce=0).
- First request: cycle after `rst` deasserts, `rom_ce_o = 1`, `rom_addr_o = RESET_PC`.
- Latency: ack in cycle t with FIFO empty and no stall → entry pushed at end of t, popped at end of t+1, visible on `pc_o`/`inst_o` in cycle t+2.
- Throughput: zero-wait memory (ack every cycle) sustains 1 instruction/cycle with no bubbles after fill.
- Flush in cycle t: `inst_valid_o = 0` in t+1; first request to new PC issued in t+1; earliest valid redirected instruction in t+3.
- All outputs except `rom_ce_o`/`rom_addr_o` are registered; those two depend combinationally only on registered state, `rst`, `flush_i`.

## Test plan
- Reset, zero-wait memory returning word = addr ^ 32'hA5A5_0000: `rom_addr_o` 0,4,8,…; `pc_o` 0,4,8,… from cycle 3 post-reset, one per cycle, `inst_valid_o` held 1.
- Memory with 2 wait states per fetch: addr held 3 cycles per ack; `inst_valid_o` pulses 1 cycle in 3, nop (0) bubbles between, no address skipped or duplicated.
- `stall_i` high 10 cycles, zero-wait memory: outputs frozen, exactly DEPTH(4) acks accepted then `rom_ce_o = 0`; on release, 4 buffered pcs emerge back-to-back in order, fetch resumes.
- `flush_i` with `new_pc_i = 32'h0000_1003` while FIFO holds 3 entries and a request is waiting: next fetch addr 32'h0000_1000, stale entries never reach `pc_o`, first valid `pc_o` = 32'h0000_1000.
- Flush in same cycle as ack and `stall_i = 1`: acked word discarded, outputs cleared to nop/invalid despite stall.
- Redirect to 32'hFFFF_FFF8: fetch addresses …FFF8, …FFFC, 0, 4; `pc_o` follows wrap in order. Assert `rst` mid-wait: `rom_ce_o` 0 during reset, restart at RESET_PC.
